pipelined_array_multiplier: RTL

Parametrised successor to the fixed-width array multiplier: an A_WIDTH × B_WIDTH carry-save array multiplier with configurable pipeline-register placement and a per-transaction signed/unsigned mode. It uses Baugh-Wooley correction for signed operands and adds a valid/ready handshake with full backpressure and a synchronous flush. It sits in the datapath library as the drop-in multiply unit for retiming and timing-closure experiments.

---
 rtl/mult_pkg.sv | 32 +++
 rtl/full_adder.sv | 15 +
 rtl/pipeline_stage_en.sv | 45 ++++
 rtl/pipelined_array_multiplier.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared helpers for the pipelined array multiplier: stage placement and signed correction.
// Latency: none (compile-time functions and constants only).
// Backpressure: not applicable.
package mult_pkg;

  // Widest mask or product vector the helper functions can describe
  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] wide_t;

  // Register-point enable vector for points 0..width. The output point (bit width)
  // is always on. The other num_stages-1 points are the lowest indices.
  function automatic wide_t stage_mask(input int width, input int num_stages);
    wide_t m;
    m = '0;
    for (int k = 0; k < num_stages - 1; k++) begin
      m[k] = 1'b1;
    end
    m[width] = 1'b1;
    return m;
  endfunction

  // Baugh-Wooley constant for an a_w x b_w signed array. It is added once per signed product.
  // The two half-weight terms sit at columns a_w-1 and b_w-1. They merge into column a_w
  // when the widths are equal. The top term is the wrapped -2^(a_w+b_w-1).
  function automatic wide_t bw_corr(input int a_w, input int b_w);
    wide_t c;
    c = (wide_t'(1) << (a_w - 1)) + (wide_t'(1) << (b_w - 1)) + (wide_t'(1) << (a_w + b_w - 1));
    return c;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used for the carry-save rows.
// Latency: combinational.
// Backpressure: not applicable.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/pipeline_stage_en.sv
// Optional pipeline register point carrying a data word plus a valid bit.
// Latency: 1 cycle when ENABLE=1, combinational pass-through when ENABLE=0.
// Backpressure: holds data and valid while advance=0; flush clears valid regardless of advance.
module pipeline_stage_en #(
  parameter int WIDTH  = 8,
  parameter bit ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (ENABLE) begin : g_reg
      // Register point: flush drops the valid bit even when stalled; the data word only moves on advance
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end else begin
          if (flush) begin
            out_valid <= 1'b0;
          end else if (advance) begin
            out_valid <= in_valid;
          end
          if (advance) begin
            out_data <= in_data;
          end
        end
      end
    end else begin : g_wire
      // A disabled point is a plain wire, so the control inputs have no effect here
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, advance, flush};
      assign out_valid   = in_valid;
      assign out_data    = in_data;
    end
  endgenerate

endmodule

// File: rtl/pipelined_array_multiplier.sv
// A_WIDTH x B_WIDTH carry-save array multiplier with a per-transaction signed/unsigned mode (Baugh-Wooley).
// Latency: NUM_PIPELINE_STAGES cycles from accept to o_valid, plus any stall cycles.
// Backpressure: global stall, i_ready = !o_valid || o_ready (forced to 1 during i_flush).
module pipelined_array_multiplier
  import mult_pkg::*;
#(
  parameter int A_WIDTH             = 8,
  parameter int B_WIDTH             = 8,
  parameter int NUM_PIPELINE_STAGES = 2,
  parameter int INSTANCE_ID         = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic                       i_signed,
  input  logic [A_WIDTH-1:0]         A,
  input  logic [B_WIDTH-1:0]         B,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] Z_final,
  output logic                       o_signed
);

  localparam int P = A_WIDTH + B_WIDTH;
  localparam wide_t MASK_FULL = stage_mask(B_WIDTH, NUM_PIPELINE_STAGES);
  localparam logic [B_WIDTH:0] EN = MASK_FULL[B_WIDTH:0];
  localparam wide_t CORR_FULL = bw_corr(A_WIDTH, B_WIDTH);
  localparam logic [P-1:0] CORR = CORR_FULL[P-1:0];

  // Payload between points: operands still needed by later rows, plus the carry-save pair
  typedef struct packed {
    logic               sgn;
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
    logic [P-1:0]       sum;
    logic [P-1:0]       cry;
  } stage_t;

  typedef struct packed {
    logic         sgn;
    logic [P-1:0] z;
  } out_t;

  // Tag for synthesis/retiming scripts only
  logic [31:0] unused_instance_id;
  assign unused_instance_id = INSTANCE_ID;

  logic   advance;
  stage_t in_d;
  stage_t st_q  [0:B_WIDTH-1];
  logic   st_vld[0:B_WIDTH-1];
  stage_t row_d [1:B_WIDTH];
  out_t   out_d;
  out_t   out_q;

  assign advance = !o_valid || o_ready;
  assign i_ready = advance || i_flush;

  // Idle operands are zeroed so the array does not toggle. A signed product seeds the sum with its correction constant.
  assign in_d = '{
    sgn: i_signed & i_valid,
    a:   A & {A_WIDTH{i_valid}},
    b:   B & {B_WIDTH{i_valid}},
    sum: (i_valid && i_signed) ? CORR : '0,
    cry: '0
  };

  pipeline_stage_en #(.WIDTH($bits(stage_t)), .ENABLE(EN[0])) u_pt0 (
    .clk       (clk),
    .rst       (rst),
    .advance   (advance),
    .flush     (i_flush),
    .in_valid  (i_valid),
    .in_data   (in_d),
    .out_valid (st_vld[0]),
    .out_data  (st_q[0])
  );

  generate
    for (genvar k = 1; k <= B_WIDTH; k++) begin : g_row
      logic [P-1:0] pp;
      logic [P-1:0] s_vec;
      logic [P-2:0] c_vec;

      // Partial products of row k-1. In signed mode, terms with exactly one operand MSB are inverted.
      always_comb begin
        pp = '0;
        for (int i = 0; i < A_WIDTH; i++) begin
          pp[i+k-1] = (st_q[k-1].a[i] & st_q[k-1].b[k-1]) ^
                      (st_q[k-1].sgn & ((i == A_WIDTH - 1) ^ (k == B_WIDTH)));
        end
      end

      for (genvar j = 0; j < P - 1; j++) begin : g_fa
        full_adder u_fa (
          .a    (st_q[k-1].sum[j]),
          .b    (st_q[k-1].cry[j]),
          .cin  (pp[j]),
          .s    (s_vec[j]),
          .cout (c_vec[j])
        );
      end
      // The top column's carry would leave the product width, so only its sum is kept
      assign s_vec[P-1] = st_q[k-1].sum[P-1] ^ st_q[k-1].cry[P-1] ^ pp[P-1];

      assign row_d[k] = '{
        sgn: st_q[k-1].sgn,
        a:   st_q[k-1].a,
        b:   st_q[k-1].b,
        sum: s_vec,
        cry: {c_vec, 1'b0}
      };

      if (k < B_WIDTH) begin : g_pt
        pipeline_stage_en #(.WIDTH($bits(stage_t)), .ENABLE(EN[k])) u_pt (
          .clk       (clk),
          .rst       (rst),
          .advance   (advance),
          .flush     (i_flush),
          .in_valid  (st_vld[k-1]),
          .in_data   (row_d[k]),
          .out_valid (st_vld[k]),
          .out_data  (st_q[k])
        );
      end
    end
  endgenerate

  // Final carry-propagate add collapses the carry-save pair into the product
  assign out_d = '{
    sgn: row_d[B_WIDTH].sgn,
    z:   row_d[B_WIDTH].sum + row_d[B_WIDTH].cry
  };

  pipeline_stage_en #(.WIDTH($bits(out_t)), .ENABLE(1'b1)) u_pt_out (
    .clk       (clk),
    .rst       (rst),
    .advance   (advance),
    .flush     (i_flush),
    .in_valid  (st_vld[B_WIDTH-1]),
    .in_data   (out_d),
    .out_valid (o_valid),
    .out_data  (out_q)
  );

  assign Z_final  = out_q.z;
  assign o_signed = out_q.sgn;

endmodule
